cpu_trace_encoder: RTL and testbench

CPU_TRACE_ENCODER -- requirements
Module: cpu_trace_encoder

---
 rtl/cpu_trace_encoder_pkg.sv | 42 ++++
 rtl/cpu_trace_encoder_fifo.sv | 53 +++++
 rtl/cpu_trace_encoder.sv | 126 ++++++++++++
 tb/tb_cpu_trace_encoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_encoder_pkg.sv
// Shared types for the retirement trace encoder: record type codes,
// W0 field positions and the four-beat record payload.
package cpu_trace_encoder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REC_W  = 4 * WORD_W;

  typedef enum logic [2:0] {
    TR_NONE = 3'd0,
    TR_RF   = 3'd1,
    TR_MEM  = 3'd2,
    TR_BR   = 3'd3,
    TR_JAL  = 3'd4
  } tr_type_e;

  localparam int unsigned W0_TYPE_LSB  = 29;
  localparam int unsigned W0_WADDR_LSB = 24;
  localparam int unsigned W0_WSTRB_LSB = 20;
  localparam int unsigned W0_MRD_BIT   = 19;

  // w0 is the first beat on the wire and sits in the low word
  typedef struct packed {
    logic [WORD_W-1:0] w3;
    logic [WORD_W-1:0] w2;
    logic [WORD_W-1:0] w1;
    logic [WORD_W-1:0] w0;
  } trace_rec_t;

  function automatic logic [WORD_W-1:0] make_w0(input tr_type_e rtype,
                                                input logic [4:0] waddr,
                                                input logic [3:0] wstrb,
                                                input logic       mem_read);
    logic [WORD_W-1:0] w;
    w = '0;
    w[W0_TYPE_LSB  +: 3] = rtype;
    w[W0_WADDR_LSB +: 5] = waddr;
    w[W0_WSTRB_LSB +: 4] = wstrb;
    w[W0_MRD_BIT]        = mem_read;
    return w;
  endfunction

endpackage

// File: rtl/cpu_trace_encoder_fifo.sv
// Record buffer: power-of-two deep, wrapping pointers plus an occupancy count
// so full and empty are distinguishable. Push while full needs a same-cycle pop.
module trace_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 128
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_trace_encoder.sv
// Packs each retiring instruction into a four-beat trace record, buffers it,
// and streams it out with valid/ready; records that find no room are counted.
module cpu_trace_encoder
  import cpu_trace_encoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              commit_valid,
  input  logic [31:0]       PC,
  input  logic [31:0]       next_PC,
  input  logic              RF_wen,
  input  logic [4:0]        RF_waddr,
  input  logic [31:0]       RF_wdata,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [31:0]       Address,
  input  logic [3:0]        Write_strb,
  input  logic [31:0]       Write_data,
  input  logic              is_branch,
  input  logic              is_link,
  output logic              trace_valid,
  output logic [31:0]       trace_data,
  output logic              trace_last,
  input  logic              trace_ready,
  output logic              overflow,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  trace_rec_t    rec;
  trace_rec_t    head;
  tr_type_e      rec_type;
  logic [4:0]    rec_waddr;
  logic [3:0]    rec_wstrb;
  logic          rec_mrd;
  logic [1:0]    beat;
  logic          xfer;
  logic          pop;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW:0]   fifo_count;

  // Classify the retiring instruction; MemWrite wins over branch over link
  always_comb begin
    rec_type  = TR_RF;
    rec_waddr = '0;
    rec_wstrb = '0;
    rec_mrd   = 1'b0;
    rec       = '0;
    if (MemWrite) begin
      rec_type  = TR_MEM;
      rec_wstrb = Write_strb;
      rec.w2    = Address;
      rec.w3    = Write_data;
    end else if (is_branch) begin
      rec_type  = TR_BR;
      rec.w2    = next_PC;
    end else if (is_link) begin
      rec_type  = TR_JAL;
      rec_waddr = RF_waddr;
      rec.w2    = RF_wdata;
      rec.w3    = next_PC;
    end else begin
      rec_type  = TR_RF;
      rec_waddr = RF_wen ? RF_waddr : 5'd0;
      rec_mrd   = MemRead;
      rec.w2    = RF_wdata;
    end
    rec.w1 = PC;
    rec.w0 = make_w0(rec_type, rec_waddr, rec_wstrb, rec_mrd);
  end

  assign trace_valid = (fifo_count != '0);
  assign xfer        = trace_valid && trace_ready;
  assign pop         = trace_ready && !fifo_empty && (beat == 2'd3);
  assign drop        = commit_valid && fifo_full && !pop;
  assign trace_last  = trace_valid && (beat == 2'd3);

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (commit_valid),
    .pop    (pop),
    .wdata  (rec),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Beat select from the head record; forced to zero when nothing is buffered
  always_comb begin
    trace_data = '0;
    if (trace_valid) begin
      case (beat)
        2'd0:    trace_data = head.w0;
        2'd1:    trace_data = head.w1;
        2'd2:    trace_data = head.w2;
        default: trace_data = head.w3;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat     <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (xfer) beat <= beat + 2'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpu_trace_encoder.sv
// Directed bench for cpu_trace_encoder: table of single-record vectors plus
// sequences for overflow, full-with-pop and mid-record reset.
module tb_cpu_trace_encoder;

  localparam int unsigned CNT_W = 16;

  logic              clk = 1'b0;
  logic              resetn;
  logic              commit_valid;
  logic [31:0]       PC, next_PC, RF_wdata, Address, Write_data;
  logic              RF_wen, MemWrite, MemRead, is_branch, is_link;
  logic [4:0]        RF_waddr;
  logic [3:0]        Write_strb;
  logic              trace_valid, trace_last, trace_ready, overflow;
  logic [31:0]       trace_data;
  logic [CNT_W-1:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_trace_encoder #(.FIFO_DEPTH(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .commit_valid(commit_valid),
    .PC(PC), .next_PC(next_PC), .RF_wen(RF_wen), .RF_waddr(RF_waddr),
    .RF_wdata(RF_wdata), .MemWrite(MemWrite), .MemRead(MemRead),
    .Address(Address), .Write_strb(Write_strb), .Write_data(Write_data),
    .is_branch(is_branch), .is_link(is_link), .trace_valid(trace_valid),
    .trace_data(trace_data), .trace_last(trace_last), .trace_ready(trace_ready),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic        mw, mr, br, lk, wen;
    logic [4:0]  waddr;
    logic [3:0]  strb;
    logic [31:0] pc, npc, wdata, addr, wd;
    logic [31:0] e0, e2, e3;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input vec_t v);
    MemWrite = v.mw; MemRead = v.mr; is_branch = v.br; is_link = v.lk;
    RF_wen = v.wen; RF_waddr = v.waddr; Write_strb = v.strb;
    PC = v.pc; next_PC = v.npc; RF_wdata = v.wdata; Address = v.addr;
    Write_data = v.wd;
  endtask

  function automatic vec_t rf_vec(input logic [31:0] pc, input logic [31:0] wdata);
    vec_t v;
    v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 4'h0, pc, pc + 32'd4, wdata,
          32'h0, 32'h0, 32'h2100_0000, wdata, 32'h0};
    return v;
  endfunction

  // Check the four beats of one record with trace_ready held high
  task automatic expect_rec(input string tag, input vec_t v);
    logic [31:0] exp [4];
    exp[0] = v.e0; exp[1] = v.pc; exp[2] = v.e2; exp[3] = v.e3;
    for (int b = 0; b < 4; b++) begin
      chk({tag, "_valid"}, 32'(trace_valid), 32'd1);
      chk({tag, "_data"}, trace_data, exp[b]);
      chk({tag, "_last"}, 32'(trace_last), (b == 3) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{0,0,0,0,1, 5'd8,  4'h0, 32'h10, 32'h14,  32'h5,    32'h0,   32'h0,
                32'h2800_0000, 32'h5, 32'h0};
    vecs[1] = '{1,0,0,0,1, 5'd3,  4'hF, 32'h14, 32'h18,  32'h77,   32'h100, 32'hDEAD_BEEF,
                32'h40F0_0000, 32'h100, 32'hDEAD_BEEF};
    vecs[2] = '{0,0,0,1,1, 5'd31, 4'h0, 32'h20, 32'h80,  32'h28,   32'h0,   32'h0,
                32'h9F00_0000, 32'h28, 32'h80};
    vecs[3] = '{0,0,1,0,0, 5'd5,  4'hF, 32'h30, 32'h40,  32'h11,   32'h22,  32'h33,
                32'h6000_0000, 32'h40, 32'h0};
    vecs[4] = '{0,1,0,0,1, 5'd2,  4'h0, 32'h34, 32'h38,  32'h1234, 32'h500, 32'h0,
                32'h2208_0000, 32'h1234, 32'h0};
    vecs[5] = '{1,1,1,1,1, 5'd9,  4'h3, 32'h38, 32'h3C,  32'h66,   32'h200, 32'h55AA,
                32'h4030_0000, 32'h200, 32'h55AA};
    vecs[6] = '{0,1,1,1,1, 5'd31, 4'h0, 32'h3C, 32'h100, 32'h7,    32'h0,   32'h0,
                32'h6000_0000, 32'h100, 32'h0};
    vecs[7] = '{0,1,0,0,0, 5'd7,  4'h0, 32'h44, 32'h48,  32'h99,   32'h0,   32'h0,
                32'h2008_0000, 32'h99, 32'h0};

    // Reset with a commit pending: must be ignored
    resetn = 1'b0; trace_ready = 1'b0; commit_valid = 1'b1;
    set_in(vecs[0]);
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(trace_valid), 32'd0);
    chk("rst_last", 32'(trace_last), 32'd0);
    chk("rst_data", trace_data, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    commit_valid = 1'b0; resetn = 1'b1;
    @(negedge clk);
    chk("rst_ignored", 32'(trace_valid), 32'd0);

    // Table vectors, one record each
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("pre_empty", 32'(trace_valid), 32'd0);
      set_in(vecs[i]); commit_valid = 1'b1;
      @(negedge clk);
      commit_valid = 1'b0;
      if (i == 2) begin
        chk("v2_b0", trace_data, vecs[i].e0);
        @(negedge clk);
        trace_ready = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("stall_data", trace_data, vecs[i].pc);
          chk("stall_last", 32'(trace_last), 32'd0);
        end
        trace_ready = 1'b1;
        @(negedge clk);
        chk("v2_b2", trace_data, vecs[i].e2);
        @(negedge clk);
        chk("v2_b3", trace_data, vecs[i].e3);
        chk("v2_last", 32'(trace_last), 32'd1);
        @(negedge clk);
      end else begin
        expect_rec($sformatf("vec%0d", i), vecs[i]);
      end
    end
    chk("post_empty", 32'(trace_valid), 32'd0);

    // Nine commits into an eight-deep buffer with the consumer stalled
    trace_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) chk("ovf_before", 32'(overflow), 32'd0);
      set_in(rf_vec(32'h1000 + 32'(4 * i), 32'(i))); commit_valid = 1'b1;
      @(negedge clk);
    end
    commit_valid = 1'b0;
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop", 32'(drop_cnt), 32'd1);
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) expect_rec("ovf_drain", rf_vec(32'h1000 + 32'(4 * i), 32'(i)));
    chk("ovf_9th_absent", 32'(trace_valid), 32'd0);

    // Full buffer: commit coinciding with the beat-3 pop is kept
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_in(rf_vec(32'h2000 + 32'(4 * i), 32'h100 + 32'(i))); commit_valid = 1'b1;
      @(negedge clk);
    end
    commit_valid = 1'b0;
    trace_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("full_last", 32'(trace_last), 32'd1);
    set_in(rf_vec(32'h3000, 32'hABC)); commit_valid = 1'b1;
    @(negedge clk);
    commit_valid = 1'b0;
    chk("full_nodrop", 32'(drop_cnt), 32'd1);
    trace_ready = 1'b0;
    set_in(rf_vec(32'h3004, 32'hDEF)); commit_valid = 1'b1;
    @(negedge clk);
    commit_valid = 1'b0;
    chk("full_drop", 32'(drop_cnt), 32'd2);
    chk("full_ovf", 32'(overflow), 32'd1);
    trace_ready = 1'b1;
    for (int i = 1; i < 8; i++) expect_rec("full_drain", rf_vec(32'h2000 + 32'(4 * i), 32'h100 + 32'(i)));
    expect_rec("full_new", rf_vec(32'h3000, 32'hABC));
    chk("full_count8", 32'(trace_valid), 32'd0);

    // Reset in the middle of a record
    set_in(vecs[0]); commit_valid = 1'b1;
    @(negedge clk);
    commit_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_beat2", trace_data, vecs[0].e2);
    resetn = 1'b0;
    set_in(vecs[1]); commit_valid = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(trace_valid), 32'd0);
    chk("mid_rst_data", trace_data, 32'd0);
    chk("mid_rst_last", 32'(trace_last), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    commit_valid = 1'b0; resetn = 1'b1;
    @(negedge clk);
    chk("mid_rel_empty", 32'(trace_valid), 32'd0);
    v = vecs[2];
    set_in(v); commit_valid = 1'b1;
    @(negedge clk);
    commit_valid = 1'b0;
    expect_rec("mid_after", v);
    chk("mid_end_empty", 32'(trace_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
